ravenoc_pkt_inject: RTL and testbench



---
 rtl/ravenoc_pkg.sv | 33 +++
 rtl/ravenoc_flit_reg.sv | 40 ++++
 rtl/ravenoc_pkt_inject.sv | 126 ++++++++++++
 tb/tb_ravenoc_pkt_inject.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared flit types and default NoC widths for the RaveNoC local injector.
// Revision 1.0
`default_nettype none

package ravenoc_pkg;

  localparam int FLIT_DATA_WIDTH = 32;
  localparam int X_W             = 2;
  localparam int Y_W             = 2;
  localparam int PKT_SZ_W        = 8;
  localparam int VC_W            = 1;

  typedef enum logic [1:0] {
    HEAD_FLIT      = 2'd0,
    BODY_FLIT      = 2'd1,
    TAIL_FLIT      = 2'd2,
    HEAD_TAIL_FLIT = 2'd3
  } flit_type_t;

  // Head flit as seen on flit_o for the default widths, MSB first.
  typedef struct packed {
    flit_type_t                                      flit_type;
    logic [X_W-1:0]                                  x_dest;
    logic [Y_W-1:0]                                  y_dest;
    logic [X_W-1:0]                                  x_src;
    logic [Y_W-1:0]                                  y_src;
    logic [PKT_SZ_W-1:0]                             pkt_size;
    logic [FLIT_DATA_WIDTH-2*X_W-2*Y_W-PKT_SZ_W-1:0] rsvd;
  } s_flit_head_t;

endpackage

`default_nettype wire

// File: rtl/ravenoc_flit_reg.sv
// ravenoc_flit_reg: single-entry valid/ready output register; out_free marks when it may load.
// Revision 1.0
`default_nettype none

module ravenoc_flit_reg #(
  parameter int FLIT_W = 34,
  parameter int VC_W   = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              load,
  input  logic [FLIT_W-1:0] next_flit,
  input  logic [VC_W-1:0]   next_vc,
  input  logic              ready,
  output logic              valid,
  output logic [FLIT_W-1:0] flit,
  output logic [VC_W-1:0]   vc,
  output logic              out_free
);

  assign out_free = !valid || ready;

  // Data and VC only move on a load, so they stay frozen while stalled.
  always_ff @(posedge clk) begin
    if (!arst) begin
      valid <= 1'b0;
      flit  <= '0;
      vc    <= '0;
    end else if (out_free) begin
      valid <= load;
      if (load) begin
        flit <= next_flit;
        vc   <= next_vc;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ravenoc_pkt_inject.sv
// ravenoc_pkt_inject: turns per-packet commands plus payload words into HEAD/BODY/TAIL flits.
// Revision 1.0
`default_nettype none

module ravenoc_pkt_inject #(
  parameter int ROUTER_X_ID     = 0,
  parameter int ROUTER_Y_ID     = 0,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int X_W             = 2,
  parameter int Y_W             = 2,
  parameter int PKT_SZ_W        = 8,
  parameter int VC_W            = 1
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [X_W-1:0]             cmd_x_i,
  input  logic [Y_W-1:0]             cmd_y_i,
  input  logic [VC_W-1:0]            cmd_vc_i,
  input  logic [PKT_SZ_W-1:0]        cmd_len_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  input  logic [FLIT_DATA_WIDTH-1:0] data_i,
  output logic                       flit_valid_o,
  input  logic                       flit_ready_i,
  output logic [FLIT_DATA_WIDTH+1:0] flit_o,
  output logic [VC_W-1:0]            vc_id_o,
  output logic                       busy_o
);

  import ravenoc_pkg::*;

  localparam int FLIT_W = FLIT_DATA_WIDTH + 2;
  localparam int PAD_W  = FLIT_DATA_WIDTH - 2*X_W - 2*Y_W - PKT_SZ_W;
  localparam logic [X_W-1:0] SRC_X = X_W'(ROUTER_X_ID);
  localparam logic [Y_W-1:0] SRC_Y = Y_W'(ROUTER_Y_ID);

  typedef enum logic {ST_IDLE, ST_BODY} state_t;

  state_t                     state, state_next;
  logic [PKT_SZ_W-1:0]        rem, rem_next;
  logic [VC_W-1:0]            vc_q, vc_next;
  logic                       out_free;
  logic                       load;
  logic [FLIT_W-1:0]          load_flit;
  logic [VC_W-1:0]            load_vc;
  logic [FLIT_DATA_WIDTH-1:0] head_fields;

  assign head_fields = {cmd_x_i, cmd_y_i, SRC_X, SRC_Y, cmd_len_i, {PAD_W{1'b0}}};
  assign busy_o      = (state == ST_BODY);

  always_comb begin
    state_next   = state;
    rem_next     = rem;
    vc_next      = vc_q;
    cmd_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    load         = 1'b0;
    load_flit    = '0;
    load_vc      = vc_q;
    case (state)
      ST_IDLE: begin
        cmd_ready_o = out_free;
        if (cmd_valid_i && out_free) begin
          load     = 1'b1;
          load_vc  = cmd_vc_i;
          vc_next  = cmd_vc_i;
          rem_next = cmd_len_i;
          if (cmd_len_i == '0) begin
            load_flit = {HEAD_TAIL_FLIT, head_fields};
          end else begin
            load_flit  = {HEAD_FLIT, head_fields};
            state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        data_ready_o = out_free;
        if (data_valid_i && out_free) begin
          load     = 1'b1;
          rem_next = rem - PKT_SZ_W'(1);
          // The word that brings rem to zero closes the packet.
          if (rem == PKT_SZ_W'(1)) begin
            load_flit  = {TAIL_FLIT, data_i};
            state_next = ST_IDLE;
          end else begin
            load_flit = {BODY_FLIT, data_i};
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      state <= ST_IDLE;
      rem   <= '0;
      vc_q  <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
      vc_q  <= vc_next;
    end
  end

  ravenoc_flit_reg #(
    .FLIT_W (FLIT_W),
    .VC_W   (VC_W)
  ) u_flit_reg (
    .clk       (clk),
    .arst      (arst),
    .load      (load),
    .next_flit (load_flit),
    .next_vc   (load_vc),
    .ready     (flit_ready_i),
    .valid     (flit_valid_o),
    .flit      (flit_o),
    .vc        (vc_id_o),
    .out_free  (out_free)
  );

endmodule

`default_nettype wire

// File: tb/tb_ravenoc_pkt_inject.sv
// tb_ravenoc_pkt_inject: self-checking bench with a packet-level reference model.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_ravenoc_pkt_inject;

  localparam int SRC_X = 0;
  localparam int SRC_Y = 0;
  localparam int TMO   = 2000;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_x_i = '0;
  logic [1:0]  cmd_y_i = '0;
  logic [0:0]  cmd_vc_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [31:0] data_i = '0;
  logic        flit_valid_o;
  logic        flit_ready_i = 1'b1;
  logic [33:0] flit_o;
  logic [0:0]  vc_id_o;
  logic        busy_o;

  ravenoc_pkt_inject #(
    .ROUTER_X_ID(SRC_X), .ROUTER_Y_ID(SRC_Y), .FLIT_DATA_WIDTH(32),
    .X_W(2), .Y_W(2), .PKT_SZ_W(8), .VC_W(1)
  ) dut (
    .clk(clk), .arst(arst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_vc_i(cmd_vc_i), .cmd_len_i(cmd_len_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready_i),
    .flit_o(flit_o), .vc_id_o(vc_id_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] f;
    logic        vc;
    int          cyc;
  } rec_t;

  rec_t        obs[$];
  rec_t        exp_q[$];
  logic [31:0] word_tbl[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          rnd_on;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change only at posedge+1, so a negedge sample shows the upcoming handshake.
  always @(negedge clk)
    if (arst && flit_valid_o && flit_ready_i) obs.push_back('{flit_o, vc_id_o[0], cyc});

  function automatic logic [33:0] mk_head(int x, int y, int len);
    longint t = (len == 0) ? 3 : 0;
    return 34'((t << 32) | (longint'(x) << 30) | (longint'(y) << 28) |
               (longint'(SRC_X) << 26) | (longint'(SRC_Y) << 24) | (longint'(len) << 16));
  endfunction

  function automatic logic [33:0] mk_data(int t, logic [31:0] d);
    return 34'((longint'(t) << 32) | longint'(d));
  endfunction

  task automatic do_cmd(input int x, input int y, input int vc, input int len);
    int n = 0;
    cmd_valid_i = 1'b1; cmd_x_i = 2'(x); cmd_y_i = 2'(y); cmd_vc_i = 1'(vc); cmd_len_i = 8'(len);
    @(negedge clk);
    while (!cmd_ready_o && n < TMO) begin @(negedge clk); n++; end
    checks++;
    if (n >= TMO) begin errors++; $display("FAIL cmd_handshake timeout got none want accept"); end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic do_word(input logic [31:0] d);
    int n = 0;
    data_valid_i = 1'b1; data_i = d;
    @(negedge clk);
    while (!data_ready_o && n < TMO) begin @(negedge clk); n++; end
    checks++;
    if (n >= TMO) begin errors++; $display("FAIL data_handshake timeout got none want accept"); end
    @(posedge clk); #1;
    data_valid_i = 1'b0;
  endtask

  task automatic send_packet(input int x, input int y, input int vc, input int len);
    logic [31:0] words[$];
    logic [31:0] d;
    exp_q.push_back('{mk_head(x, y, len), 1'(vc), 0});
    for (int i = 0; i < len; i++) begin
      d = (word_tbl.size() > 0) ? word_tbl.pop_front() : $urandom;
      words.push_back(d);
      exp_q.push_back('{mk_data((i == len - 1) ? 2 : 1, d), 1'(vc), 0});
    end
    do_cmd(x, y, vc, len);
    foreach (words[i]) do_word(words[i]);
  endtask

  task automatic test_reset();
    arst = 1'b0; cmd_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (flit_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", flit_valid_o); end
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
    checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL rst_data_ready got %b want 0", data_ready_o); end
    checks++; if (flit_o !== 34'd0 || vc_id_o !== 1'b0) begin errors++; $display("FAIL rst_flit got %h/%b want 0/0", flit_o, vc_id_o); end
    @(posedge clk); #1;
    arst = 1'b1; cmd_valid_i = 1'b0;
  endtask

  task automatic test_zero_len();
    send_packet(1, 2, 1, 0);
    checks++; if (flit_valid_o !== 1'b1 || flit_o !== mk_head(1, 2, 0)) begin errors++; $display("FAIL zero_len_flit got %b/%h want 1/%h", flit_valid_o, flit_o, mk_head(1, 2, 0)); end
    checks++; if (vc_id_o !== 1'b1) begin errors++; $display("FAIL zero_len_vc got %b want 1", vc_id_o); end
    checks++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin errors++; $display("FAIL zero_len_idle got busy=%b rdy=%b want 0/1", busy_o, cmd_ready_o); end
    repeat (3) @(posedge clk); #1;
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL zero_len_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i].f !== exp_q[i].f || obs[i].vc !== exp_q[i].vc) begin errors++; $display("FAIL zero_len_flit%0d got %h/%b want %h/%b", i, obs[i].f, obs[i].vc, exp_q[i].f, exp_q[i].vc); end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_three_body();
    word_tbl = '{32'hA, 32'hB, 32'hC};
    send_packet(3, 1, 0, 3);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL three_busy_after_tail got %b want 0", busy_o); end
    repeat (3) @(posedge clk); #1;
    checks++; if (obs.size() !== 4) begin errors++; $display("FAIL three_count got %0d want 4", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i].f !== exp_q[i].f || obs[i].vc !== exp_q[i].vc) begin errors++; $display("FAIL three_flit%0d got %h/%b want %h/%b", i, obs[i].f, obs[i].vc, exp_q[i].f, exp_q[i].vc); end
      if (i > 0) begin
        checks++; if (obs[i].cyc - obs[i-1].cyc !== 1) begin errors++; $display("FAIL three_gap%0d got %0d want 1", i, obs[i].cyc - obs[i-1].cyc); end
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    fork
      send_packet(2, 2, 1, 4);
      begin
        repeat (2) @(posedge clk); #1;
        flit_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++; if (flit_valid_o !== 1'b1 || flit_o !== exp_q[obs.size()].f) begin errors++; $display("FAIL bp_hold%0d got %b/%h want 1/%h", k, flit_valid_o, flit_o, exp_q[obs.size()].f); end
          checks++; if (vc_id_o !== 1'b1 || data_ready_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL bp_ctl%0d got vc=%b drdy=%b busy=%b want 1/0/1", k, vc_id_o, data_ready_o, busy_o); end
        end
        @(posedge clk); #1;
        flit_ready_i = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i].f !== exp_q[i].f || obs[i].vc !== exp_q[i].vc) begin errors++; $display("FAIL bp_flit%0d got %h/%b want %h/%b", i, obs[i].f, obs[i].vc, exp_q[i].f, exp_q[i].vc); end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_packet(2, 3, 0, 2);
    send_packet(3, 0, 1, 0);
    repeat (3) @(posedge clk); #1;
    checks++; if (obs.size() !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i].f !== exp_q[i].f || obs[i].vc !== exp_q[i].vc) begin errors++; $display("FAIL b2b_flit%0d got %h/%b want %h/%b", i, obs[i].f, obs[i].vc, exp_q[i].f, exp_q[i].vc); end
      if (i > 0) begin
        checks++; if (obs[i].cyc - obs[i-1].cyc !== 1) begin errors++; $display("FAIL b2b_gap%0d got %0d want 1", i, obs[i].cyc - obs[i-1].cyc); end
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    exp_q.push_back('{mk_head(1, 3, 4), 1'b1, 0});
    exp_q.push_back('{mk_data(1, w0), 1'b1, 0});
    do_cmd(1, 3, 1, 4);
    do_word(w0);
    do_word(w1);
    arst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (flit_valid_o !== 1'b0 || flit_o !== 34'd0 || vc_id_o !== 1'b0) begin errors++; $display("FAIL mid_rst_out got %b/%h/%b want 0/0/0", flit_valid_o, flit_o, vc_id_o); end
    checks++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || data_ready_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got busy=%b crdy=%b drdy=%b want 0/1/0", busy_o, cmd_ready_o, data_ready_o); end
    @(posedge clk); #1;
    arst = 1'b1;
    send_packet(2, 2, 0, 1);
    repeat (3) @(posedge clk); #1;
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL mid_rst_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i].f !== exp_q[i].f || obs[i].vc !== exp_q[i].vc) begin errors++; $display("FAIL mid_rst_flit%0d got %h/%b want %h/%b", i, obs[i].f, obs[i].vc, exp_q[i].f, exp_q[i].vc); end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    rnd_on = 1'b1;
    fork
      begin
        for (int p = 0; p < 25; p++)
          send_packet($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                      (p == 10) ? 255 : $urandom_range(0, 6));
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          if (rnd_on) flit_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    flit_ready_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i].f !== exp_q[i].f || obs[i].vc !== exp_q[i].vc) begin errors++; $display("FAIL rand_flit%0d got %h/%b want %h/%b", i, obs[i].f, obs[i].vc, exp_q[i].f, exp_q[i].vc); end
    end
    obs.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_three_body();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
